// File: rtl/board_display_scanner.sv
// Row-multiplexed bicolour 3x3 LED scanner with frame-synchronous board snapshot,
// game-status FSM, winner/draw blinking and turn lamps.
module board_display_scanner #(
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       Clk,
  input  logic       reset_n,
  input  logic [8:0] P1_cells,
  input  logic [8:0] P2_cells,
  input  logic       P1_W,
  input  logic       P2_W,
  input  logic       board_full,
  input  logic       turn,
  output logic [2:0] row_sel,
  output logic [2:0] col_p1,
  output logic [2:0] col_p2,
  output logic       turn_led_p1,
  output logic       turn_led_p2,
  output logic [1:0] status,
  output logic       conflict,
  output logic       frame_tick
);

  localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  typedef enum logic [1:0] {
    PLAY = 2'b00,
    WIN1 = 2'b01,
    WIN2 = 2'b10,
    DRAW = 2'b11
  } state_e;

  logic          run_q;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [1:0]    row_q, row_d;
  logic [8:0]    sh1_q, sh2_q;
  state_e        state_q, state_d;
  logic [BW-1:0] blink_cnt_q;
  logic          phase_q;
  logic          snap;

  logic [2:0]    row_sel_q, row_sel_d;
  logic [2:0]    col1_q, col1_d, col2_q, col2_d;
  logic          tl1_q, tl2_q;
  logic          conflict_q;
  logic          tick_q, tick_d;

  logic [2:0]    r1, r2;
  logic          gate1, gate2;

  // Scan position for the next cycle; the first cycle after reset parks on row 0 dwell 0.
  always_comb begin
    dwell_d = dwell_q;
    row_d   = row_q;
    if (!run_q) begin
      dwell_d = '0;
      row_d   = 2'd0;
    end else if (dwell_q == DWELL_LAST) begin
      dwell_d = '0;
      row_d   = (row_q == 2'd2) ? 2'd0 : row_q + 2'd1;
    end else begin
      dwell_d = dwell_q + DW'(1);
    end
  end

  assign snap   = (row_d == 2'd0) && (!run_q || (row_q != 2'd0));
  assign tick_d = (row_d == 2'd2) && (dwell_d == DWELL_LAST);

  always_comb begin
    row_sel_d = 3'b000;
    row_sel_d[row_d] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      PLAY: begin
        if (P1_W && !P2_W)      state_d = WIN1;
        else if (P2_W && !P1_W) state_d = WIN2;
        else if (P1_W && P2_W)  state_d = DRAW;
        else if (board_full)    state_d = DRAW;
      end
      default: begin
        if ((P1_cells == 9'd0) && (P2_cells == 9'd0)) state_d = PLAY;
      end
    endcase
  end

  always_comb begin
    case (row_d)
      2'd0:    begin r1 = sh1_q[2:0]; r2 = sh2_q[2:0]; end
      2'd1:    begin r1 = sh1_q[5:3]; r2 = sh2_q[5:3]; end
      default: begin r1 = sh1_q[8:6]; r2 = sh2_q[8:6]; end
    endcase
  end

  assign gate1 = phase_q || !((state_q == WIN1) || (state_q == DRAW));
  assign gate2 = phase_q || !((state_q == WIN2) || (state_q == DRAW));

  // Doubly-claimed cells are shown dark in both colours; dwell 0 blanks the row.
  always_comb begin
    col1_d = 3'b000;
    col2_d = 3'b000;
    if (dwell_d != '0) begin
      col1_d = gate1 ? (r1 & ~r2) : 3'b000;
      col2_d = gate2 ? (r2 & ~r1) : 3'b000;
    end
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q       <= 1'b0;
      dwell_q     <= '0;
      row_q       <= 2'd0;
      sh1_q       <= 9'd0;
      sh2_q       <= 9'd0;
      state_q     <= PLAY;
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
      row_sel_q   <= 3'b000;
      col1_q      <= 3'b000;
      col2_q      <= 3'b000;
      tl1_q       <= 1'b0;
      tl2_q       <= 1'b0;
      conflict_q  <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      run_q     <= 1'b1;
      dwell_q   <= dwell_d;
      row_q     <= row_d;
      row_sel_q <= row_sel_d;
      col1_q    <= col1_d;
      col2_q    <= col2_d;
      tick_q    <= tick_d;
      state_q   <= state_d;
      tl1_q     <= (state_d == PLAY) && turn;
      tl2_q     <= (state_d == PLAY) && !turn;
      conflict_q <= conflict_q || (|(sh1_q & sh2_q));
      if (snap) begin
        sh1_q <= P1_cells;
        sh2_q <= P2_cells;
      end
      // PLAY holds the blink at phase ON, so entering a terminal state starts fresh.
      if (state_q == PLAY) begin
        blink_cnt_q <= '0;
        phase_q     <= 1'b1;
      end else if (tick_q) begin
        if (blink_cnt_q == BLINK_LAST) begin
          blink_cnt_q <= '0;
          phase_q     <= !phase_q;
        end else begin
          blink_cnt_q <= blink_cnt_q + BW'(1);
        end
      end
    end
  end

  assign row_sel     = row_sel_q;
  assign col_p1      = col1_q;
  assign col_p2      = col2_q;
  assign turn_led_p1 = tl1_q;
  assign turn_led_p2 = tl2_q;
  assign status      = state_q;
  assign conflict    = conflict_q;
  assign frame_tick  = tick_q;

endmodule

// File: tb/tb_board_display_scanner.sv
// Directed scoreboard bench for board_display_scanner (SCAN_DIV=4, BLINK_FRAMES=2).
module tb_board_display_scanner;

  logic       Clk = 1'b0;
  logic       reset_n;
  logic [8:0] P1_cells, P2_cells;
  logic       P1_W, P2_W, board_full, turn;
  logic [2:0] row_sel, col_p1, col_p2;
  logic       turn_led_p1, turn_led_p2;
  logic [1:0] status;
  logic       conflict, frame_tick;

  board_display_scanner #(.SCAN_DIV(4), .BLINK_FRAMES(2)) dut (
    .Clk(Clk), .reset_n(reset_n), .P1_cells(P1_cells), .P2_cells(P2_cells),
    .P1_W(P1_W), .P2_W(P2_W), .board_full(board_full), .turn(turn),
    .row_sel(row_sel), .col_p1(col_p1), .col_p2(col_p2),
    .turn_led_p1(turn_led_p1), .turn_led_p2(turn_led_p2),
    .status(status), .conflict(conflict), .frame_tick(frame_tick)
  );

  always #5 Clk = ~Clk;

  // Bench-side scan position: cycles since reset release.
  int cyc;
  always @(posedge Clk or negedge reset_n)
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;

  function automatic int cur_r();
    return ((cyc - 1) / 4) % 3;
  endfunction
  function automatic int cur_d();
    return (cyc - 1) % 4;
  endfunction

  typedef struct {
    string       tag;
    logic [14:0] v;
  } exp_t;
  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;

  // {row_sel, col_p1, col_p2, led1, led2, status, conflict, frame_tick}; r<0 means no row.
  function automatic logic [14:0] mk(input int r, input int d, input logic [2:0] c1,
                                      input logic [2:0] c2, input logic t1, input logic t2,
                                      input logic [1:0] st, input logic cf);
    logic [2:0] rs;
    logic       ft;
    rs = 3'b000;
    if (r >= 0) rs[r] = 1'b1;
    ft = (r == 2) && (d == 3);
    return {rs, c1, c2, t1, t2, st, cf, ft};
  endfunction

  task automatic push(input string tag, input logic [14:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    exp_q.push_back(e);
  endtask

  task automatic check();
    exp_t        e;
    logic [14:0] obs;
    e   = exp_q.pop_front();
    obs = {row_sel, col_p1, col_p2, turn_led_p1, turn_led_p2, status, conflict, frame_tick};
    total++;
    assert (obs === e.v) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.v);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_pos(input int r, input int d);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!(cur_r() == r && cur_d() == d) && n < 60);
    if (!(cur_r() == r && cur_d() == d)) begin
      total++;
      bad++;
      $error("FAIL wait_pos_timeout observed=%0d/%0d expected=%0d/%0d", cur_r(), cur_d(), r, d);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    P1_cells = 9'd0; P2_cells = 9'd0;
    P1_W = 1'b0; P2_W = 1'b0; board_full = 1'b0; turn = 1'b0;
    repeat (3) step();
    push("reset", mk(-1, 0, 3'b000, 3'b000, 1'b0, 1'b0, 2'b00, 1'b0));
    check();

    // 1: idle scan, every cycle of two frames
    @(negedge Clk) reset_n = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      step();
      push($sformatf("idle_k%0d", k), mk(((k - 1) / 4) % 3, (k - 1) % 4, 3'b000, 3'b000,
                                          1'b0, 1'b1, 2'b00, 1'b0));
      check();
    end

    // 2: one mark per player, full frame
    P1_cells = 9'h001; P2_cells = 9'h010; turn = 1'b1;
    for (int k = 25; k <= 36; k++) begin
      int r, d;
      r = ((k - 1) / 4) % 3;
      d = (k - 1) % 4;
      push($sformatf("marks_k%0d", k), mk(r, d, (d != 0 && r == 0) ? 3'b001 : 3'b000,
                                           (d != 0 && r == 1) ? 3'b010 : 3'b000,
                                           1'b1, 1'b0, 2'b00, 1'b0));
      step();
      check();
    end

    // 3: mid-frame input change waits for the next frame
    wait_pos(1, 1);
    P1_cells = 9'h002;
    push("snap_r1", mk(1, 2, 3'b000, 3'b010, 1'b1, 1'b0, 2'b00, 1'b0));
    step(); check();
    push("snap_r2", mk(2, 1, 3'b000, 3'b000, 1'b1, 1'b0, 2'b00, 1'b0));
    wait_pos(2, 1); check();
    push("snap_new_r0", mk(0, 1, 3'b010, 3'b000, 1'b1, 1'b0, 2'b00, 1'b0));
    wait_pos(0, 1); check();
    push("snap_new_r1", mk(1, 1, 3'b000, 3'b010, 1'b1, 1'b0, 2'b00, 1'b0));
    wait_pos(1, 1); check();

    // 4: player-1 win, blink 2 frames on / 2 off, then clear
    wait_pos(2, 3);
    P1_cells = 9'h007; P1_W = 1'b1;
    push("win1_entry", mk(0, 0, 3'b000, 3'b000, 1'b0, 1'b0, 2'b01, 1'b0));
    step(); check();
    push("win1_f1_r0", mk(0, 1, 3'b111, 3'b000, 1'b0, 1'b0, 2'b01, 1'b0));
    wait_pos(0, 1); check();
    push("win1_f1_r1", mk(1, 1, 3'b000, 3'b010, 1'b0, 1'b0, 2'b01, 1'b0));
    wait_pos(1, 1); check();
    push("win1_f2_r0", mk(0, 1, 3'b111, 3'b000, 1'b0, 1'b0, 2'b01, 1'b0));
    wait_pos(0, 1); check();
    push("win1_f3_r0", mk(0, 1, 3'b000, 3'b000, 1'b0, 1'b0, 2'b01, 1'b0));
    wait_pos(0, 1); check();
    push("win1_f3_r1_steady", mk(1, 1, 3'b000, 3'b010, 1'b0, 1'b0, 2'b01, 1'b0));
    wait_pos(1, 1); check();
    push("win1_f4_r0", mk(0, 1, 3'b000, 3'b000, 1'b0, 1'b0, 2'b01, 1'b0));
    wait_pos(0, 1); check();
    push("win1_f5_r0", mk(0, 1, 3'b111, 3'b000, 1'b0, 1'b0, 2'b01, 1'b0));
    wait_pos(0, 1); check();
    P1_cells = 9'd0; P2_cells = 9'd0; P1_W = 1'b0;
    push("win1_clear", mk(0, 2, 3'b111, 3'b000, 1'b1, 1'b0, 2'b00, 1'b0));
    step(); check();
    push("win1_cleared_frame", mk(0, 1, 3'b000, 3'b000, 1'b1, 1'b0, 2'b00, 1'b0));
    wait_pos(0, 1); check();

    // 5: draw on full board, both colours blink; then win beats board_full
    wait_pos(2, 3);
    P1_cells = 9'h001; P2_cells = 9'h002; board_full = 1'b1;
    push("draw_entry", mk(0, 0, 3'b000, 3'b000, 1'b0, 1'b0, 2'b11, 1'b0));
    step(); check();
    push("draw_f1", mk(0, 1, 3'b001, 3'b010, 1'b0, 1'b0, 2'b11, 1'b0));
    wait_pos(0, 1); check();
    push("draw_f2", mk(0, 1, 3'b001, 3'b010, 1'b0, 1'b0, 2'b11, 1'b0));
    wait_pos(0, 1); check();
    push("draw_f3_off", mk(0, 1, 3'b000, 3'b000, 1'b0, 1'b0, 2'b11, 1'b0));
    wait_pos(0, 1); check();
    P1_cells = 9'd0; P2_cells = 9'd0; board_full = 1'b0;
    push("draw_clear", mk(0, 2, 3'b000, 3'b000, 1'b1, 1'b0, 2'b00, 1'b0));
    step(); check();
    push("draw_cleared_frame", mk(0, 1, 3'b000, 3'b000, 1'b1, 1'b0, 2'b00, 1'b0));
    wait_pos(0, 1); check();
    board_full = 1'b1; P2_W = 1'b1;
    push("win2_over_full", mk(0, 2, 3'b000, 3'b000, 1'b0, 1'b0, 2'b10, 1'b0));
    step(); check();
    board_full = 1'b0; P2_W = 1'b0;
    push("win2_clear", mk(0, 3, 3'b000, 3'b000, 1'b1, 1'b0, 2'b00, 1'b0));
    step(); check();

    // 6: conflicting cell, sticky flag, reset mid-frame
    wait_pos(2, 3);
    P1_cells = 9'h101; P2_cells = 9'h100;
    push("conf_r0", mk(0, 1, 3'b001, 3'b000, 1'b1, 1'b0, 2'b00, 1'b1));
    wait_pos(0, 1); check();
    push("conf_cellI_blank", mk(2, 1, 3'b000, 3'b000, 1'b1, 1'b0, 2'b00, 1'b1));
    wait_pos(2, 1); check();
    P1_cells = 9'd0; P2_cells = 9'd0;
    push("conf_sticky_r0", mk(0, 1, 3'b000, 3'b000, 1'b1, 1'b0, 2'b00, 1'b1));
    wait_pos(0, 1); check();
    push("conf_sticky_r2", mk(2, 1, 3'b000, 3'b000, 1'b1, 1'b0, 2'b00, 1'b1));
    wait_pos(2, 1); check();
    wait_pos(1, 1);
    reset_n = 1'b0;
    #1;
    push("midframe_reset", mk(-1, 0, 3'b000, 3'b000, 1'b0, 1'b0, 2'b00, 1'b0));
    check();
    @(negedge Clk) reset_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      push($sformatf("restart_k%0d", k), mk(((k - 1) / 4) % 3, (k - 1) % 4, 3'b000, 3'b000,
                                             1'b1, 1'b0, 2'b00, 1'b0));
      check();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
